// File: rtl/fp_norm_pkg.sv
// Shared constants and types for the normalisation control stage and its
// leading-zero counter.
package fp_norm_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int SELECT_WIDTH = 5;
  localparam int EXP_WIDTH    = 8;

  typedef logic [SELECT_WIDTH:0]   lz_t;
  typedef logic [SELECT_WIDTH-1:0] shift_t;
  typedef logic [EXP_WIDTH-1:0]    exp_t;
  typedef logic [EXP_WIDTH:0]      exp_cmp_t;
  typedef logic [DATA_WIDTH-1:0]   mant_t;

  typedef struct packed {
    logic zero;
    logic underflow;
  } norm_flags_t;

endpackage

// File: rtl/fp_norm_shift_ctrl_lzc_32.sv
// Combinational leading-zero counter for a 32-bit mantissa.
// An all-zero mantissa reports DATA_WIDTH.
module lzc_32
  import fp_norm_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] mant,
  output logic [SELECT_WIDTH:0] lz
);

  // Scan upward so the highest set bit is the last one to write lz.
  always_comb begin
    lz = lz_t'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (mant[i]) lz = lz_t'(DATA_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_shift_ctrl.sv
// Normalisation control ahead of the 32-bit left barrel shifter: counts leading
// zeros, clamps the shift for subnormal results, 2-stage valid/ready pipeline.
module fp_norm_shift_ctrl
  import fp_norm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_mant,
  input  logic [EXP_WIDTH-1:0]    in_exp,
  input  logic                    in_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_mant,
  output logic [SELECT_WIDTH-1:0] out_shift_num,
  output logic [EXP_WIDTH-1:0]    out_exp,
  output logic                    out_sign,
  output logic                    out_zero,
  output logic                    out_underflow
);

  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv, in_fire;
  mant_t       s1_mant;
  exp_t        s1_exp;
  logic        s1_sign;
  lz_t         s1_lz, in_lz;
  shift_t      nxt_shift;
  exp_t        nxt_exp;
  norm_flags_t nxt_flags, s2_flags;

  lzc_32 u_lzc (
    .mant (in_mant),
    .lz   (in_lz)
  );

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_lz    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_sign <= in_sign;
        s1_lz   <= in_lz;
      end
    end
  end

  // Once lz reaches the exponent the result is subnormal; exponents 0 and 1
  // share a scale, so the shift stops at exp-1.
  always_comb begin
    nxt_shift = '0;
    nxt_exp   = '0;
    nxt_flags = '0;
    if (s1_lz == lz_t'(DATA_WIDTH)) begin
      nxt_flags.zero = 1'b1;
    end else if (exp_cmp_t'(s1_lz) < exp_cmp_t'(s1_exp)) begin
      nxt_shift = s1_lz[SELECT_WIDTH-1:0];
      nxt_exp   = s1_exp - exp_t'(s1_lz);
    end else begin
      nxt_flags.underflow = 1'b1;
      nxt_shift = (s1_exp == '0) ? '0 : shift_t'(s1_exp - exp_t'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      out_mant      <= '0;
      out_shift_num <= '0;
      out_exp       <= '0;
      out_sign      <= 1'b0;
      s2_flags      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant      <= s1_mant;
        out_shift_num <= nxt_shift;
        out_exp       <= nxt_exp;
        out_sign      <= s1_sign;
        s2_flags      <= nxt_flags;
      end
    end
  end

  assign out_valid     = s2_valid;
  assign out_zero      = s2_flags.zero;
  assign out_underflow = s2_flags.underflow;

endmodule
